// File: rtl/spi_xfer_ctrl.sv
// Transaction sequencer for the SPI transmit engine: runs CMD, ADDR, DUMMY and DATA
// phases inside one chip-select frame, then holds cs_n low for CS_HOLD_CYC clocks.
module spi_xfer_ctrl #(
    parameter int CS_HOLD_CYC = 2,
    parameter int DLY_W       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      cfg_cmd,
    input  logic [5:0]       cfg_cmd_len,
    input  logic [31:0]      cfg_addr,
    input  logic [5:0]       cfg_addr_len,
    input  logic [DLY_W-1:0] cfg_dummy,
    input  logic [15:0]      cfg_data_len,
    input  logic [2:0]       cfg_quad,
    input  logic [31:0]      wdata,
    input  logic             wvalid,
    output logic             wready,
    input  logic             tx_edge,
    input  logic             tx_done,
    input  logic             tx_data_ready,
    output logic             tx_en,
    output logic             tx_quad,
    output logic [15:0]      tx_counter,
    output logic             tx_counter_upd,
    output logic [31:0]      tx_data,
    output logic             tx_data_valid,
    output logic             dummy_clk_en,
    output logic             cs_n,
    output logic             busy,
    output logic             done,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CMD_LOAD  = 4'd1,
        S_CMD_RUN   = 4'd2,
        S_ADDR_LOAD = 4'd3,
        S_ADDR_RUN  = 4'd4,
        S_DUMMY     = 4'd5,
        S_DATA_LOAD = 4'd6,
        S_DATA_RUN  = 4'd7,
        S_HOLD      = 4'd8
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(CS_HOLD_CYC - 1);

    state_t           state, state_nxt;
    logic [31:0]      cmd_q, addr_q;
    logic [15:0]      cmd_len_q, addr_len_q, data_len_q;
    logic [2:0]       quad_q;
    logic [DLY_W-1:0] dly_cnt;
    logic [3:0]       hold_cnt;
    logic             word_sent;
    logic [15:0]      cmd_len_in, addr_len_in, data_len_in;
    logic             has_cmd, has_addr, has_dummy, has_data;
    logic             hold_last;

    function automatic logic [15:0] bit_len(input logic [5:0] len);
        bit_len = (len > 6'd32) ? 16'd32 : {10'd0, len};
    endfunction

    // Quad phases shift 4 bits per edge, so the length is truncated to a nibble multiple.
    function automatic logic [15:0] lane_len(input logic [15:0] len, input logic quad);
        lane_len = quad ? {len[15:2], 2'b00} : len;
    endfunction

    // after: 0 = from start, 1 = after CMD, 2 = after ADDR, 3 = after DUMMY
    function automatic state_t next_phase(input logic [1:0] after, input logic c,
                                          input logic a, input logic d, input logic w);
        if (after == 2'd0 && c)       return S_CMD_LOAD;
        else if (after <= 2'd1 && a)  return S_ADDR_LOAD;
        else if (after <= 2'd2 && d)  return S_DUMMY;
        else if (w)                   return S_DATA_LOAD;
        else                          return S_HOLD;
    endfunction

    assign cmd_len_in  = lane_len(bit_len(cfg_cmd_len), cfg_quad[0]);
    assign addr_len_in = lane_len(bit_len(cfg_addr_len), cfg_quad[1]);
    assign data_len_in = lane_len(cfg_data_len, cfg_quad[2]);

    // In IDLE the first phase is chosen from the live cfg; afterwards from the latched copy.
    assign has_cmd   = (state == S_IDLE) ? (cmd_len_in != 16'd0)  : (cmd_len_q != 16'd0);
    assign has_addr  = (state == S_IDLE) ? (addr_len_in != 16'd0) : (addr_len_q != 16'd0);
    assign has_dummy = (state == S_IDLE) ? (cfg_dummy != '0)      : (dly_cnt != '0);
    assign has_data  = (state == S_IDLE) ? (data_len_in != 16'd0) : (data_len_q != 16'd0);
    assign hold_last = (hold_cnt == HOLD_LAST);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cs_n       <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_q      <= '0;
            addr_q     <= '0;
            cmd_len_q  <= '0;
            addr_len_q <= '0;
            data_len_q <= '0;
            quad_q     <= '0;
            dly_cnt    <= '0;
            hold_cnt   <= '0;
            word_sent  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    cmd_q      <= cfg_cmd;
                    addr_q     <= cfg_addr;
                    cmd_len_q  <= cmd_len_in;
                    addr_len_q <= addr_len_in;
                    data_len_q <= data_len_in;
                    quad_q     <= cfg_quad;
                    dly_cnt    <= cfg_dummy;
                    busy       <= 1'b1;
                    cs_n       <= 1'b0;
                end
            end else if (abort) begin
                busy <= 1'b0;
                cs_n <= 1'b1;
            end else if (state == S_HOLD && hold_last) begin
                busy <= 1'b0;
                cs_n <= 1'b1;
                done <= 1'b1;
            end

            if (state == S_DUMMY && tx_edge && dly_cnt != '0)
                dly_cnt <= dly_cnt - 1'b1;

            hold_cnt <= (state == S_HOLD) ? hold_cnt + 4'd1 : 4'd0;

            if (state == S_CMD_LOAD || state == S_ADDR_LOAD)
                word_sent <= 1'b0;
            else if ((state == S_CMD_RUN || state == S_ADDR_RUN) && tx_data_ready)
                word_sent <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = next_phase(2'd0, has_cmd, has_addr, has_dummy, has_data);
            S_CMD_LOAD:  state_nxt = S_CMD_RUN;
            S_CMD_RUN:   if (tx_done) state_nxt = next_phase(2'd1, has_cmd, has_addr, has_dummy, has_data);
            S_ADDR_LOAD: state_nxt = S_ADDR_RUN;
            S_ADDR_RUN:  if (tx_done) state_nxt = next_phase(2'd2, has_cmd, has_addr, has_dummy, has_data);
            S_DUMMY:     if (tx_edge && dly_cnt == DLY_W'(1))
                             state_nxt = next_phase(2'd3, has_cmd, has_addr, has_dummy, has_data);
            S_DATA_LOAD: state_nxt = S_DATA_RUN;
            S_DATA_RUN:  if (tx_done) state_nxt = S_HOLD;
            S_HOLD:      if (hold_last) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (state != S_IDLE && abort)
            state_nxt = S_IDLE;
    end

    always_comb begin
        tx_en          = 1'b0;
        tx_quad        = 1'b0;
        tx_counter     = 16'd0;
        tx_counter_upd = 1'b0;
        tx_data        = 32'd0;
        tx_data_valid  = 1'b0;
        wready         = 1'b0;
        dummy_clk_en   = 1'b0;
        case (state)
            S_CMD_LOAD, S_CMD_RUN: begin
                tx_counter     = cmd_len_q;
                tx_quad        = quad_q[0];
                tx_counter_upd = (state == S_CMD_LOAD);
                tx_en          = (state == S_CMD_RUN);
                tx_data        = (state == S_CMD_RUN) ? cmd_q : 32'd0;
                tx_data_valid  = (state == S_CMD_RUN) && !word_sent;
            end
            S_ADDR_LOAD, S_ADDR_RUN: begin
                tx_counter     = addr_len_q;
                tx_quad        = quad_q[1];
                tx_counter_upd = (state == S_ADDR_LOAD);
                tx_en          = (state == S_ADDR_RUN);
                tx_data        = (state == S_ADDR_RUN) ? addr_q : 32'd0;
                tx_data_valid  = (state == S_ADDR_RUN) && !word_sent;
            end
            S_DUMMY: dummy_clk_en = 1'b1;
            S_DATA_LOAD: begin
                tx_counter     = data_len_q;
                tx_quad        = quad_q[2];
                tx_counter_upd = 1'b1;
            end
            S_DATA_RUN: begin
                tx_counter    = data_len_q;
                tx_quad       = quad_q[2];
                tx_en         = 1'b1;
                tx_data       = wdata;
                tx_data_valid = wvalid;
                wready        = tx_data_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: a behavioural engine/FIFO drives the DUT, a monitor
// pops an expected-event queue on every LOAD, word handshake and done pulse.
module tb_spi_xfer_ctrl;

    localparam int CS_HOLD_CYC = 2;
    localparam int DLY_W       = 8;
    localparam int W           = 36;

    logic             clk, rstn, start, abort;
    logic [31:0]      cfg_cmd, cfg_addr;
    logic [5:0]       cfg_cmd_len, cfg_addr_len;
    logic [DLY_W-1:0] cfg_dummy;
    logic [15:0]      cfg_data_len;
    logic [2:0]       cfg_quad;
    logic [31:0]      wdata;
    logic             wvalid, wready;
    logic             tx_edge, tx_done, tx_data_ready;
    logic             tx_en, tx_quad, tx_counter_upd, tx_data_valid, dummy_clk_en;
    logic [15:0]      tx_counter;
    logic [31:0]      tx_data;
    logic             cs_n, busy, done;
    logic [3:0]       dbg_state;

    logic [W-1:0] exp_q[$];
    logic [31:0]  fifo_q[$];
    int checks = 0;
    int errors = 0;
    int cs_glitch = 0;
    int pops = 0;
    int dummy_edges = 0;
    logic eng_off = 1'b0;

    spi_xfer_ctrl #(.CS_HOLD_CYC(CS_HOLD_CYC), .DLY_W(DLY_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .cfg_cmd(cfg_cmd), .cfg_cmd_len(cfg_cmd_len), .cfg_addr(cfg_addr),
        .cfg_addr_len(cfg_addr_len), .cfg_dummy(cfg_dummy), .cfg_data_len(cfg_data_len),
        .cfg_quad(cfg_quad), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .tx_edge(tx_edge), .tx_done(tx_done), .tx_data_ready(tx_data_ready),
        .tx_en(tx_en), .tx_quad(tx_quad), .tx_counter(tx_counter),
        .tx_counter_upd(tx_counter_upd), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
        .dummy_clk_en(dummy_clk_en), .cs_n(cs_n), .busy(busy), .done(done),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ev_load(input logic [15:0] n, input logic q);
        return {2'd0, 16'd0, n, 1'b0, q};
    endfunction
    function automatic logic [W-1:0] ev_data(input logic [31:0] d);
        return {2'd1, 2'd0, d};
    endfunction
    function automatic logic [W-1:0] ev_done();
        return {2'd2, 34'd0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s act=%h req=%h", name, act, req);
        end
    endtask

    task automatic sb_check(input string name, input logic [W-1:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected act=%h req=none", name, act);
        end else begin
            check(name, 64'(act), 64'(exp_q.pop_front()));
        end
    endtask

    // monitor
    initial forever begin
        @(negedge clk);
        #2;
        if (rstn) begin
            if (tx_counter_upd)                 sb_check("load", ev_load(tx_counter, tx_quad));
            if (tx_data_valid && tx_data_ready) sb_check("xfer", ev_data(tx_data));
            if (done)                           sb_check("done", ev_done());
            if (busy && cs_n)                   cs_glitch++;
        end
    end

    // write-data FIFO head
    initial forever begin
        @(posedge clk);
        #2;
        wvalid = (fifo_q.size() != 0);
        wdata  = (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
    end

    // engine model: one handshake per 32-bit word, then tx_done; one tx_edge per dummy cycle
    initial begin
        int words, k;
        logic ok, do_pop;
        forever begin
            @(negedge clk);
            if (rstn && tx_counter_upd && !eng_off) begin
                words = (int'(tx_counter) + 31) / 32;
                ok = 1'b1;
                for (int w = 0; w < words && ok; w++) begin
                    k = 0;
                    @(negedge clk);
                    while (!(tx_data_valid && tx_en) && busy && k < 300) begin
                        @(negedge clk);
                        k++;
                    end
                    if (!busy) begin
                        ok = 1'b0;
                    end else if (k >= 300) begin
                        checks++;
                        errors++;
                        $display("FAIL engine_wait act=timeout req=tx_data_valid");
                        ok = 1'b0;
                    end else begin
                        tx_data_ready = 1'b1;
                        #1 do_pop = wready;
                        @(posedge clk);
                        #1 tx_data_ready = 1'b0;
                        if (do_pop && fifo_q.size() != 0) begin
                            void'(fifo_q.pop_front());
                            pops++;
                        end
                        repeat (2) @(negedge clk);
                    end
                end
                if (ok) begin
                    @(negedge clk);
                    tx_done = 1'b1;
                    @(posedge clk);
                    #1 tx_done = 1'b0;
                end
            end else if (rstn && dummy_clk_en) begin
                tx_edge = 1'b1;
                dummy_edges++;
                @(posedge clk);
                #1 tx_edge = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic set_cfg(input logic [31:0] c, input logic [5:0] cl, input logic [31:0] a,
                           input logic [5:0] al, input logic [DLY_W-1:0] d,
                           input logic [15:0] dl, input logic [2:0] q);
        cfg_cmd = c; cfg_cmd_len = cl; cfg_addr = a; cfg_addr_len = al;
        cfg_dummy = d; cfg_data_len = dl; cfg_quad = q;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int k = 0;
        while (!done && k < bound) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic end_test(input string name);
        repeat (4) @(posedge clk);
        check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        check({name, "_cs_frame"}, 64'(cs_glitch), 64'd0);
        cs_glitch = 0;
        pops = 0;
        dummy_edges = 0;
    endtask

    initial begin
        int n;
        rstn = 1'b0; start = 1'b0; abort = 1'b0;
        tx_edge = 1'b0; tx_done = 1'b0; tx_data_ready = 1'b0;
        wvalid = 1'b0; wdata = 32'd0;
        set_cfg(32'd0, 6'd0, 32'd0, 6'd0, '0, 16'd0, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 64'(cs_n), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tx_en", 64'(tx_en), 64'd0);
        check("rst_tx_counter", 64'(tx_counter), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_strobes", 64'({tx_counter_upd, tx_data_valid, wready, dummy_clk_en, tx_quad}), 64'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // single-lane command only
        set_cfg(32'h9F000000, 6'd8, 32'd0, 6'd0, '0, 16'd0, 3'b000);
        exp_q.push_back(ev_load(16'd8, 1'b0));
        exp_q.push_back(ev_data(32'h9F000000));
        exp_q.push_back(ev_done());
        pulse_start();
        #1 check("t1_cs_low", 64'(cs_n), 64'd0);
        wait_done("t1_done", 200);
        check("t1_cs_release", 64'(cs_n), 64'd1);
        end_test("t1");

        // quad read setup: cmd single, addr quad, 6 dummy edges
        set_cfg(32'hEB000000, 6'd8, 32'h12345600, 6'd24, 8'd6, 16'd0, 3'b010);
        exp_q.push_back(ev_load(16'd8, 1'b0));
        exp_q.push_back(ev_data(32'hEB000000));
        exp_q.push_back(ev_load(16'd24, 1'b1));
        exp_q.push_back(ev_data(32'h12345600));
        exp_q.push_back(ev_done());
        pulse_start();
        wait_done("t2_done", 300);
        check("t2_dummy_edges", 64'(dummy_edges), 64'd6);
        end_test("t2");

        // 64-bit single-lane write
        fifo_q.push_back(32'hDEADBEEF);
        fifo_q.push_back(32'hCAFEF00D);
        set_cfg(32'd0, 6'd0, 32'd0, 6'd0, '0, 16'd64, 3'b000);
        exp_q.push_back(ev_load(16'd64, 1'b0));
        exp_q.push_back(ev_data(32'hDEADBEEF));
        exp_q.push_back(ev_data(32'hCAFEF00D));
        exp_q.push_back(ev_done());
        pulse_start();
        wait_done("t3_done", 300);
        check("t3_pops", 64'(pops), 64'd2);
        end_test("t3");

        // FIFO underflow: second word arrives 20 cycles late
        fifo_q.push_back(32'h11112222);
        set_cfg(32'd0, 6'd0, 32'd0, 6'd0, '0, 16'd64, 3'b000);
        exp_q.push_back(ev_load(16'd64, 1'b0));
        exp_q.push_back(ev_data(32'h11112222));
        exp_q.push_back(ev_data(32'h33334444));
        exp_q.push_back(ev_done());
        pulse_start();
        n = 0;
        while (pops < 1 && n < 100) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("t4_first_pop", 64'(pops), 64'd1);
        repeat (20) @(posedge clk);
        #3;
        check("t4_stall_cs_n", 64'(cs_n), 64'd0);
        check("t4_stall_busy", 64'(busy), 64'd1);
        check("t4_stall_valid", 64'(tx_data_valid), 64'd0);
        fifo_q.push_back(32'h33334444);
        wait_done("t4_done", 300);
        end_test("t4");

        // abort during ADDR RUN, then a normal transaction
        eng_off = 1'b1;
        set_cfg(32'd0, 6'd0, 32'hA5A5A500, 6'd24, '0, 16'd0, 3'b000);
        exp_q.push_back(ev_load(16'd24, 1'b0));
        pulse_start();
        n = 0;
        while (!tx_en && n < 50) begin
            @(posedge clk);
            #3;
            n++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("t5_cs_n", 64'(cs_n), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_outs", 64'({tx_en, tx_data_valid, dummy_clk_en, wready}), 64'd0);
        repeat (6) @(posedge clk);
        eng_off = 1'b0;
        set_cfg(32'h06000000, 6'd8, 32'd0, 6'd0, '0, 16'd0, 3'b000);
        exp_q.push_back(ev_load(16'd8, 1'b0));
        exp_q.push_back(ev_data(32'h06000000));
        exp_q.push_back(ev_done());
        pulse_start();
        wait_done("t5_restart_done", 200);
        end_test("t5");

        // all lengths zero: HOLD only
        set_cfg(32'h0, 6'd0, 32'h0, 6'd0, '0, 16'd0, 3'b111);
        exp_q.push_back(ev_done());
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_latency", 64'(n), 64'(CS_HOLD_CYC));
        check("t6_cs_busy", 64'({cs_n, busy}), 64'b10);
        end_test("t6");

        // quad address of 3 bits rounds to 0 and is skipped
        set_cfg(32'h3B000000, 6'd8, 32'hFFFFFFFF, 6'd3, '0, 16'd0, 3'b010);
        exp_q.push_back(ev_load(16'd8, 1'b0));
        exp_q.push_back(ev_data(32'h3B000000));
        exp_q.push_back(ev_done());
        pulse_start();
        wait_done("t7_done", 200);
        end_test("t7");

        // cmd_len 40 clamps to 32; a second start and cfg change while busy are ignored
        set_cfg(32'hC0FFEE00, 6'd40, 32'd0, 6'd0, '0, 16'd0, 3'b000);
        exp_q.push_back(ev_load(16'd32, 1'b0));
        exp_q.push_back(ev_data(32'hC0FFEE00));
        exp_q.push_back(ev_done());
        pulse_start();
        set_cfg(32'h12121212, 6'd16, 32'h0, 6'd8, 8'd3, 16'd0, 3'b001);
        pulse_start();
        wait_done("t8_done", 200);
        end_test("t8");

        // quad data of 66 bits rounds to 64
        fifo_q.push_back(32'h0BADF00D);
        fifo_q.push_back(32'hFEEDFACE);
        set_cfg(32'd0, 6'd0, 32'd0, 6'd0, '0, 16'd66, 3'b100);
        exp_q.push_back(ev_load(16'd64, 1'b1));
        exp_q.push_back(ev_data(32'h0BADF00D));
        exp_q.push_back(ev_data(32'hFEEDFACE));
        exp_q.push_back(ev_done());
        pulse_start();
        wait_done("t9_done", 300);
        end_test("t9");

        // asynchronous reset while stalled in DATA
        fifo_q.push_back(32'h55AA55AA);
        set_cfg(32'd0, 6'd0, 32'd0, 6'd0, '0, 16'd64, 3'b000);
        exp_q.push_back(ev_load(16'd64, 1'b0));
        exp_q.push_back(ev_data(32'h55AA55AA));
        pulse_start();
        n = 0;
        while (pops < 1 && n < 100) begin
            @(posedge clk);
            #3;
            n++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t10_cs_n", 64'(cs_n), 64'd1);
        check("t10_busy_en", 64'({busy, tx_en}), 64'd0);
        fifo_q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        end_test("t10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
